// File: rtl/aftab_mem_pkg.sv
// rtl/aftab_mem_pkg.sv - shared encodings for the AFTAB memory port arbiter
package aftab_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  typedef enum logic {
    MASTER_M0 = 1'b0,
    MASTER_M1 = 1'b1
  } master_t;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/aftab_mem_arbiter_timer.sv
// rtl/aftab_mem_arbiter_timer.sv - strobe wait counter with one-cycle timeout pulse
import aftab_mem_pkg::*;

module aftab_mem_arbiter_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // The edge that would bring the count to TIMEOUT emits the pulse and restarts instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (!strobe || ready) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (wait_cnt == LIMIT) begin
      wait_cnt <= '0;
      timeout  <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
      timeout  <= 1'b0;
    end
  end

endmodule

// File: rtl/aftab_mem_arbiter.sv
// rtl/aftab_mem_arbiter.sv - round-robin owner of the byte-wide memory port for DARU (M0) and DAWU (M1)
import aftab_mem_pkg::*;

module aftab_mem_arbiter #(
  parameter int size    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0Busy,
  input  logic                m0Read,
  input  logic [size-1:0]     m0Addr,
  input  logic                m1Busy,
  input  logic                m1Write,
  input  logic [size-1:0]     m1Addr,
  input  logic [size/4-1:0]   m1Data,
  input  logic                memReady,
  output logic                memRead,
  output logic                memWrite,
  output logic [size-1:0]     memAddr,
  output logic [size/4-1:0]   memDataOut,
  output logic                m0Ready,
  output logic                m1Ready,
  output logic                m0Grant,
  output logic                m1Grant,
  output logic                memTimeout
);

  arb_state_t state, state_next;
  master_t    last_owner, last_owner_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= MASTER_M1;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
    end
  end

  // A releasing owner hands straight to a busy peer, so the peer never sees an idle bubble.
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      IDLE: begin
        if (m0Busy && m1Busy)
          state_next = (last_owner == MASTER_M1) ? OWN0 : OWN1;
        else if (m0Busy)
          state_next = OWN0;
        else if (m1Busy)
          state_next = OWN1;
      end
      OWN0: begin
        if (!m0Busy && !m0Read) begin
          last_owner_next = MASTER_M0;
          state_next      = m1Busy ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1Busy && !m1Write) begin
          last_owner_next = MASTER_M1;
          state_next      = m0Busy ? OWN0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m0Grant    = (state == OWN0);
  assign m1Grant    = (state == OWN1);
  assign memRead    = m0Grant & m0Read;
  assign memWrite   = m1Grant & m1Write;
  assign memAddr    = m0Grant ? m0Addr : (m1Grant ? m1Addr : '0);
  assign memDataOut = m1Grant ? m1Data : '0;
  // Ready reaches a master only while its own strobe is out on the port.
  assign m0Ready    = memReady & memRead;
  assign m1Ready    = memReady & memWrite;

  aftab_mem_arbiter_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .strobe (memRead | memWrite),
    .ready  (memReady),
    .timeout(memTimeout)
  );

endmodule

// File: tb/tb_aftab_mem_arbiter.sv
// tb/tb_aftab_mem_arbiter.sv - directed bench with a per-cycle ownership model of the memory arbiter
module tb_aftab_mem_arbiter;

  localparam int SIZE    = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0Busy, m0Read, m1Busy, m1Write, memReady;
  logic [SIZE-1:0]   m0Addr, m1Addr;
  logic [SIZE/4-1:0] m1Data;
  logic              memRead, memWrite, m0Ready, m1Ready, m0Grant, m1Grant, memTimeout;
  logic [SIZE-1:0]   memAddr;
  logic [SIZE/4-1:0] memDataOut;

  int errors = 0;
  int checks = 0;

  aftab_mem_arbiter #(.size(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0Busy(m0Busy), .m0Read(m0Read), .m0Addr(m0Addr),
    .m1Busy(m1Busy), .m1Write(m1Write), .m1Addr(m1Addr), .m1Data(m1Data),
    .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memDataOut(memDataOut),
    .m0Ready(m0Ready), .m1Ready(m1Ready), .m0Grant(m0Grant), .m1Grant(m1Grant),
    .memTimeout(memTimeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: who owns the port (-1 none), who was served last, and strobe wait age.
  int owner = -1;
  int last = 1;
  int cnt = 0;
  bit to_exp = 0;
  bit started = 0;
  bit busy_m[2];
  bit strb_m[2];
  bit strobe_m;

  always @(posedge clk) begin
    busy_m[0] = m0Busy;
    busy_m[1] = m1Busy;
    strb_m[0] = m0Read;
    strb_m[1] = m1Write;
    if (!rst) begin
      owner = -1; last = 1; cnt = 0; to_exp = 0; started = 1;
    end else begin
      strobe_m = (owner >= 0) ? strb_m[owner] : 1'b0;
      if (strobe_m && !memReady) begin
        cnt++;
        to_exp = (cnt == TIMEOUT);
        if (to_exp) cnt = 0;
      end else begin
        cnt = 0;
        to_exp = 0;
      end
      if (owner < 0) begin
        if (busy_m[0] && busy_m[1]) owner = 1 - last;
        else if (busy_m[0])         owner = 0;
        else if (busy_m[1])         owner = 1;
      end else if (!busy_m[owner] && !strb_m[owner]) begin
        last  = owner;
        owner = busy_m[1-owner] ? 1 - owner : -1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m0Grant",    m0Grant,    owner == 0);
      check("m1Grant",    m1Grant,    owner == 1);
      check("memRead",    memRead,    owner == 0 && m0Read);
      check("memWrite",   memWrite,   owner == 1 && m1Write);
      check("memAddr",    memAddr,    owner == 0 ? m0Addr : (owner == 1 ? m1Addr : 32'h0));
      check("memDataOut", memDataOut, owner == 1 ? m1Data : 8'h0);
      check("m0Ready",    m0Ready,    owner == 0 && m0Read && memReady);
      check("m1Ready",    m1Ready,    owner == 1 && m1Write && memReady);
      check("memTimeout", memTimeout, to_exp);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  int exp_owner;

  initial begin
    rst = 1'b0;
    {m0Busy, m0Read, m1Busy, m1Write, memReady} = '0;
    m0Addr = '0; m1Addr = '0; m1Data = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("reset_grant0", m0Grant, 1'b0);
    check("reset_addr", memAddr, 32'h0);

    // single M0 read
    m0Busy = 1; m0Read = 1; m0Addr = 32'h100;
    tick();
    check("t2_grant", m0Grant, 1'b1);
    check("t2_read", memRead, 1'b1);
    check("t2_addr", memAddr, 32'h100);
    memReady = 1; #1;
    check("t2_m0ready", m0Ready, 1'b1);
    check("t2_m1ready", m1Ready, 1'b0);
    tick();
    memReady = 0; m0Read = 0; m0Busy = 0;
    tick();
    check("t2_release", m0Grant, 1'b0);

    // simultaneous request after reset: M0 first, then M1 with no bubble
    do_reset();
    m0Busy = 1; m0Read = 1; m0Addr = 32'h104;
    m1Busy = 1; m1Write = 1; m1Addr = 32'h200; m1Data = 8'h5A;
    tick();
    check("t3_m0_first", m0Grant, 1'b1);
    check("t3_m1_wait", m1Grant, 1'b0);
    memReady = 1; #1;
    check("t3_m1_stall", m1Ready, 1'b0);
    tick();
    memReady = 0; m0Busy = 0; m0Read = 0;
    tick();
    check("t3_handover", m1Grant, 1'b1);
    check("t3_write", memWrite, 1'b1);
    check("t3_data", memDataOut, 32'h5A);
    check("t3_addr", memAddr, 32'h200);

    // reset while M1 owns with its write strobe high
    rst = 0;
    tick();
    check("t1_write", memWrite, 1'b0);
    check("t1_grant", m1Grant, 1'b0);
    check("t1_addr", memAddr, 32'h0);
    check("t1_data", memDataOut, 32'h0);
    rst = 1; m1Busy = 0; m1Write = 0;
    tick();

    // M1 waits out a 4-byte M0 transaction
    m0Busy = 1; m0Read = 1; m0Addr = 32'h300;
    tick();
    m1Busy = 1; m1Write = 1; m1Addr = 32'h400; m1Data = 8'hC3;
    for (int b = 0; b < 4; b++) begin
      m0Addr = 32'h300 + b;
      memReady = 1; #1;
      check("t4_m0ready", m0Ready, 1'b1);
      check("t4_m1ready", m1Ready, 1'b0);
      tick();
      memReady = 0;
      tick();
    end
    m0Busy = 0; m0Read = 0;
    tick();
    check("t4_m1grant", m1Grant, 1'b1);
    m1Busy = 0; m1Write = 0;
    tick();

    // M0 strobe starved of memReady: pulse every TIMEOUT cycles, grant kept
    m0Busy = 1; m0Read = 1; m0Addr = 32'h500;
    tick();
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("t5_timeout", memTimeout, (i == 15 || i == 30));
      check("t5_grant", m0Grant, 1'b1);
    end
    m0Busy = 0; m0Read = 0;
    tick(); tick();

    // both masters continuously busy: grants alternate starting with M0
    do_reset();
    m0Busy = 1; m0Read = 1; m1Busy = 1; m1Write = 1;
    tick();
    exp_owner = 0;
    for (int k = 0; k < 4; k++) begin
      check("t6_m0grant", m0Grant, exp_owner == 0);
      check("t6_m1grant", m1Grant, exp_owner == 1);
      if (exp_owner == 0) begin m0Busy = 0; m0Read = 0; end
      else begin m1Busy = 0; m1Write = 0; end
      tick();
      if (exp_owner == 0) begin m0Busy = 1; m0Read = 1; end
      else begin m1Busy = 1; m1Write = 1; end
      exp_owner = 1 - exp_owner;
    end
    {m0Busy, m0Read, m1Busy, m1Write} = '0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
